seg_scan_ctrl: RTL and testbench

- Sequential front end for the 3-digit decimal display path.
- Accepts a binary value over a valid/ready handshake and converts it to BCD with an iterative shift-add-3 (double-dabble) engine, one bit per clock.
- Commits the digits to a display register.
- Time-multiplexes the shared 7-segment bus across the digit selects at a programmable scan rate.

---
 rtl/seg_scan_if.sv | 43 ++++
 rtl/seg_scan_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_if
// Purpose  : Bundles the value handshake and the multiplexed display bus of
//            seg_scan_ctrl.
// Signals  : bin_in    - binary value to display (master -> slave)
//            bin_valid - requester has a value on bin_in (master -> slave)
//            bin_ready - converter idle, handshake accepted (slave -> master)
//            busy      - conversion in progress (slave -> master)
//            seg_out   - 7-segment pattern, bit0=a .. bit6=g (slave -> master)
//            dig_sel   - one-hot digit select, bit0 = ones (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface seg_scan_if #(
    parameter int BIN_WIDTH = 8,
    parameter int BCD_CNT   = 3
);
    logic [BIN_WIDTH-1:0] bin_in;
    logic                 bin_valid;
    logic                 bin_ready;
    logic                 busy;
    logic [6:0]           seg_out;
    logic [BCD_CNT-1:0]   dig_sel;

    modport master (
        output bin_in,
        output bin_valid,
        input  bin_ready,
        input  busy,
        input  seg_out,
        input  dig_sel
    );

    modport slave (
        input  bin_in,
        input  bin_valid,
        output bin_ready,
        output busy,
        output seg_out,
        output dig_sel
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Purpose  : Front end of the decimal display path. Accepts a binary value
//            over a valid/ready handshake, converts it to BCD with an
//            iterative shift-add-3 engine (one bit per clock), commits the
//            result to a display register and time-multiplexes the shared
//            7-segment bus across the digit selects.
// Ports    : clk     - system clock, rising edge
//            rst     - synchronous, active-high reset
//            scan_if - seg_scan_if.slave: bin_in/bin_valid/bin_ready/busy,
//                      seg_out (registered), dig_sel (registered one-hot)
// Params   : BIN_WIDTH - binary input width (conversion = BIN_WIDTH shifts)
//            BCD_CNT   - digit count, needs 10**BCD_CNT > 2**BIN_WIDTH-1
//            SCAN_DIV  - clocks each digit stays selected, >= 1
//            BLANK_LZ  - 1 blanks leading zero digits (digit 0 never blank)
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int BIN_WIDTH = 8,
    parameter int BCD_CNT   = 3,
    parameter int SCAN_DIV  = 1000,
    parameter bit BLANK_LZ  = 1'b1
) (
    input wire        clk,
    input wire        rst,
    seg_scan_if.slave scan_if
);

    localparam int BCD_W = 4 * BCD_CNT;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (BCD_CNT > 1) ? $clog2(BCD_CNT) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // ------------------------------------------------------------------------
    // Segment decoder, gfedcba. Codes above 9 cannot occur for legal
    // parameter sets and are shown dark.
    // ------------------------------------------------------------------------
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'h3F;
            4'd1:    pattern = 7'h06;
            4'd2:    pattern = 7'h5B;
            4'd3:    pattern = 7'h4F;
            4'd4:    pattern = 7'h66;
            4'd5:    pattern = 7'h6D;
            4'd6:    pattern = 7'h7D;
            4'd7:    pattern = 7'h07;
            4'd8:    pattern = 7'h7F;
            4'd9:    pattern = 7'h6F;
            default: pattern = 7'h00;
        endcase
        return pattern;
    endfunction

    // ------------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------------
    logic [1:0]           state_q, state_d;
    logic [BIN_WIDTH-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic [BCD_W-1:0]     bcd_adj;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BCD_W-1:0]     disp_q, disp_d;
    logic                 ready;
    logic                 busy;
    logic                 last_shift;

    // The final shift is the one taken when BIN_WIDTH-1 shifts are done.
    assign last_shift = (cnt_q == CNT_W'(BIN_WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. bin_valid outside IDLE is simply not looked at.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (scan_if.bin_valid) state_d = S_CONV;
            S_CONV: if (last_shift)        state_d = S_DONE;
            S_DONE:                        state_d = S_IDLE;
            default:                       state_d = S_IDLE;
        endcase
    end

    // Output logic, purely from state
    always_comb begin
        ready = (state_q == S_IDLE);
        busy  = (state_q == S_CONV) || (state_q == S_DONE);
    end

    assign scan_if.bin_ready = ready;
    assign scan_if.busy      = busy;

    // Add-3 correction: any nibble >= 5 would exceed 9 after doubling.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_CNT; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Datapath next state. The {bcd,bin} pair shifts left as one register;
    // the BCD MSB falling off the top is always zero for legal parameters.
    always_comb begin
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        disp_d = disp_q;
        case (state_q)
            S_IDLE: begin
                if (scan_if.bin_valid) begin
                    bin_d = scan_if.bin_in;
                    bcd_d = '0;
                    cnt_d = '0;
                end
            end
            S_CONV: begin
                bcd_d = {bcd_adj[BCD_W-2:0], bin_q[BIN_WIDTH-1]};
                bin_d = {bin_q[BIN_WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
            end
            S_DONE: begin
                // Only place the display register changes, so the scanner
                // never observes a half-converted value.
                disp_d = bcd_q;
            end
            default: begin
                bin_d = bin_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            disp_q <= '0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            disp_q <= disp_d;
        end
    end

    // ------------------------------------------------------------------------
    // Display scanner, free running and independent of the FSM
    // ------------------------------------------------------------------------
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   idx_nxt;
    logic [BCD_CNT-1:0] sel_q, sel_d;
    logic [6:0]         seg_q, seg_d;
    logic               pre_wrap;
    logic [BCD_CNT-1:0] lz_blank;
    logic               zero_run;
    logic [3:0]         nxt_digit;
    logic               nxt_blank;

    assign pre_wrap = (pre_q == PRE_W'(SCAN_DIV - 1));
    assign idx_nxt  = (idx_q == IDX_W'(BCD_CNT - 1)) ? '0 : idx_q + IDX_W'(1);

    // A digit above the ones position is dark when it and every digit above
    // it are zero; the scan walks from the top down accumulating that.
    always_comb begin
        lz_blank = '0;
        zero_run = 1'b1;
        for (int i = BCD_CNT - 1; i >= 0; i--) begin
            zero_run    = zero_run && (disp_q[4*i +: 4] == 4'd0);
            lz_blank[i] = BLANK_LZ && (i != 0) && zero_run;
        end
    end

    // Select the digit that becomes visible on the next wrap.
    always_comb begin
        nxt_digit = 4'd0;
        nxt_blank = 1'b0;
        for (int i = 0; i < BCD_CNT; i++) begin
            if (idx_nxt == IDX_W'(i)) begin
                nxt_digit = disp_q[4*i +: 4];
                nxt_blank = lz_blank[i];
            end
        end
    end

    // Select and pattern are reloaded on the same edge so they never
    // disagree on the bus.
    always_comb begin
        pre_d = pre_q + PRE_W'(1);
        idx_d = idx_q;
        sel_d = sel_q;
        seg_d = seg_q;
        if (pre_wrap) begin
            pre_d = '0;
            idx_d = idx_nxt;
            sel_d = BCD_CNT'(1) << idx_nxt;
            seg_d = nxt_blank ? 7'h00 : seg_decode(nxt_digit);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
            idx_q <= '0;
            sel_q <= BCD_CNT'(1);
            seg_q <= 7'h3F;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
            sel_q <= sel_d;
            seg_q <= seg_d;
        end
    end

    assign scan_if.dig_sel = sel_q;
    assign scan_if.seg_out = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Purpose  : Self-checking bench for seg_scan_ctrl. Two instances share the
//            stimulus: A (SCAN_DIV=4, BLANK_LZ=1) and B (SCAN_DIV=1,
//            BLANK_LZ=0). A behavioural model derives digit patterns with
//            decimal arithmetic and conversion timing with a cycle countdown.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int BW = 8;
    localparam int NC = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [BW-1:0] bin_in = '0;
    logic          bin_valid = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg_scan_if #(.BIN_WIDTH(BW), .BCD_CNT(NC)) if_a ();
    seg_scan_if #(.BIN_WIDTH(BW), .BCD_CNT(NC)) if_b ();

    assign if_a.bin_in    = bin_in;
    assign if_a.bin_valid = bin_valid;
    assign if_b.bin_in    = bin_in;
    assign if_b.bin_valid = bin_valid;

    seg_scan_ctrl #(.BIN_WIDTH(BW), .BCD_CNT(NC), .SCAN_DIV(4), .BLANK_LZ(1'b1)) dut_a (
        .clk     (clk),
        .rst     (rst),
        .scan_if (if_a)
    );

    seg_scan_ctrl #(.BIN_WIDTH(BW), .BCD_CNT(NC), .SCAN_DIV(1), .BLANK_LZ(1'b0)) dut_b (
        .clk     (clk),
        .rst     (rst),
        .scan_if (if_b)
    );

    logic [6:0]    seg_act [2];
    logic [NC-1:0] sel_act [2];
    logic          rdy_act [2];
    logic          busy_act[2];

    assign seg_act[0]  = if_a.seg_out;
    assign seg_act[1]  = if_b.seg_out;
    assign sel_act[0]  = if_a.dig_sel;
    assign sel_act[1]  = if_b.dig_sel;
    assign rdy_act[0]  = if_a.bin_ready;
    assign rdy_act[1]  = if_b.bin_ready;
    assign busy_act[0] = if_a.busy;
    assign busy_act[1] = if_b.busy;

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    int sdv[2] = '{4, 1};
    bit blk[2] = '{1'b1, 1'b0};

    // Pattern of decimal digit d of value v, with optional leading-zero blank.
    function automatic logic [6:0] pat(input int v, input int d, input bit bl);
        int p;
        int dig;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        dig = (v / p) % 10;
        if (bl && d > 0 && v < p) return 7'h00;
        case (dig)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    int         mk[2]      = '{0, 0};   // non-reset edges since reset
    logic [6:0] exp_seg[2] = '{7'h3F, 7'h3F};
    int         rem = 0;                // cycles until the display commits
    int         disp = 0;
    int         pend = 0;
    int         cyc = 0;
    int         hs_n = 0;
    int         last_hs = 0;
    int         prev_hs = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            for (int j = 0; j < 2; j++) begin
                mk[j]      = 0;
                exp_seg[j] = 7'h3F;
            end
            rem  = 0;
            disp = 0;
        end else begin
            for (int j = 0; j < 2; j++) begin
                mk[j] = mk[j] + 1;
                if (mk[j] % sdv[j] == 0)
                    exp_seg[j] = pat(disp, (mk[j] / sdv[j]) % NC, blk[j]);
            end
            if (rem > 0) begin
                rem = rem - 1;
                if (rem == 0) disp = pend;
            end else if (bin_valid) begin
                pend    = int'(bin_in);
                rem     = BW + 1;
                hs_n    = hs_n + 1;
                prev_hs = last_hs;
                last_hs = cyc;
            end
        end
    end

    // Cycle-by-cycle scoreboard of both instances against the model
    always @(negedge clk) begin
        for (int j = 0; j < 2; j++) begin
            logic [NC-1:0] es;
            es = NC'(1 << ((mk[j] / sdv[j]) % NC));
            checks++;
            if (sel_act[j] !== es) begin
                errors++;
                $display("FAIL mon_sel[%0d] t=%0t: got %b expected %b", j, $time, sel_act[j], es);
            end
            checks++;
            if (seg_act[j] !== exp_seg[j]) begin
                errors++;
                $display("FAIL mon_seg[%0d] t=%0t: got %h expected %h", j, $time, seg_act[j], exp_seg[j]);
            end
            checks++;
            if (rdy_act[j] !== (rem == 0)) begin
                errors++;
                $display("FAIL mon_ready[%0d] t=%0t: got %b expected %b", j, $time, rdy_act[j], rem == 0);
            end
            checks++;
            if (busy_act[j] !== (rem != 0)) begin
                errors++;
                $display("FAIL mon_busy[%0d] t=%0t: got %b expected %b", j, $time, busy_act[j], rem != 0);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (no comparisons inside)
    // ------------------------------------------------------------------------
    // One handshake, then count cycles with bin_ready low (bounded at 30).
    task automatic do_convert(input logic [BW-1:0] v, output int low);
        @(negedge clk);
        bin_in    = v;
        bin_valid = 1'b1;
        @(negedge clk);
        bin_valid = 1'b0;
        low = 0;
        while (low < 30 && if_a.bin_ready !== 1'b1) begin
            low++;
            @(negedge clk);
        end
    endtask

    // Record the pattern each instance shows per digit over a full scan.
    task automatic capture(output logic [20:0] ca, output logic [20:0] cb);
        ca = '0;
        cb = '0;
        repeat (16) begin
            @(negedge clk);
            for (int d = 0; d < NC; d++) begin
                if (if_a.dig_sel[d]) ca[d*7 +: 7] = if_a.seg_out;
                if (if_b.dig_sel[d]) cb[d*7 +: 7] = if_b.seg_out;
            end
        end
    endtask

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic test_reset();
        logic [2:0] es;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (if_a.dig_sel !== 3'b001 || if_a.seg_out !== 7'h3F) begin
            errors++;
            $display("FAIL reset_bus: got sel=%b seg=%h expected sel=001 seg=3F", if_a.dig_sel, if_a.seg_out);
        end
        checks++;
        if (if_a.bin_ready !== 1'b1 || if_a.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: got ready=%b busy=%b expected 1 0", if_a.bin_ready, if_a.busy);
        end
        rst = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            es = (n < 4) ? 3'b001 : (n < 8) ? 3'b010 : (n < 12) ? 3'b100 : 3'b001;
            checks++;
            if (if_a.dig_sel !== es || if_a.seg_out !== (es == 3'b001 ? 7'h3F : 7'h00)) begin
                errors++;
                $display("FAIL reset_scan n=%0d: got sel=%b seg=%h expected sel=%b", n, if_a.dig_sel, if_a.seg_out, es);
            end
        end
    endtask

    task automatic test_convert_255();
        int low;
        logic [20:0] ca, cb;
        do_convert(8'd255, low);
        checks++;
        if (low !== 9) begin
            errors++;
            $display("FAIL c255_ready_low: got %0d expected 9", low);
        end
        capture(ca, cb);
        checks++;
        if (ca !== {7'h5B, 7'h6D, 7'h6D}) begin
            errors++;
            $display("FAIL c255_segs_a: got %h expected %h", ca, {7'h5B, 7'h6D, 7'h6D});
        end
        checks++;
        if (cb !== {7'h5B, 7'h6D, 7'h6D}) begin
            errors++;
            $display("FAIL c255_segs_b: got %h expected %h", cb, {7'h5B, 7'h6D, 7'h6D});
        end
    endtask

    task automatic test_blanking();
        int low;
        logic [20:0] ca, cb;
        do_convert(8'd7, low);
        capture(ca, cb);
        checks++;
        if (ca !== {7'h00, 7'h00, 7'h07}) begin
            errors++;
            $display("FAIL blank_on: got %h expected %h", ca, {7'h00, 7'h00, 7'h07});
        end
        checks++;
        if (cb !== {7'h3F, 7'h3F, 7'h07}) begin
            errors++;
            $display("FAIL blank_off: got %h expected %h", cb, {7'h3F, 7'h3F, 7'h07});
        end
    endtask

    task automatic test_back_to_back();
        int base;
        int n;
        logic [20:0] win, ca, cb;
        base = hs_n;
        @(negedge clk);
        bin_in    = 8'd100;
        bin_valid = 1'b1;
        @(negedge clk);
        bin_in = 8'd200;
        n = 0;
        while (n < 30 && hs_n < base + 2) begin
            @(negedge clk);
            n++;
        end
        bin_valid = 1'b0;
        checks++;
        if (hs_n !== base + 2 || last_hs - prev_hs !== 10) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d handshakes spaced %0d expected 2 spaced 10", hs_n - base, last_hs - prev_hs);
        end
        win = '0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            for (int d = 0; d < NC; d++) if (if_b.dig_sel[d]) win[d*7 +: 7] = if_b.seg_out;
        end
        checks++;
        if (win !== {7'h06, 7'h3F, 7'h3F}) begin
            errors++;
            $display("FAIL b2b_first: got %h expected %h", win, {7'h06, 7'h3F, 7'h3F});
        end
        n = 0;
        while (n < 30 && if_a.bin_ready !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 30) begin
            errors++;
            $display("FAIL b2b_idle_timeout: got busy after %0d cycles expected idle", n);
        end
        capture(ca, cb);
        checks++;
        if (ca !== {7'h5B, 7'h3F, 7'h3F} || cb !== {7'h5B, 7'h3F, 7'h3F}) begin
            errors++;
            $display("FAIL b2b_second: got a=%h b=%h expected %h", ca, cb, {7'h5B, 7'h3F, 7'h3F});
        end
    endtask

    task automatic test_reset_mid();
        logic [20:0] ca, cb;
        @(negedge clk);
        bin_in    = 8'd123;
        bin_valid = 1'b1;
        @(negedge clk);
        bin_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (if_a.bin_ready !== 1'b1 || if_a.busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_state: got ready=%b busy=%b expected 1 0", if_a.bin_ready, if_a.busy);
        end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        capture(ca, cb);
        checks++;
        if (ca !== {7'h00, 7'h00, 7'h3F} || cb !== {7'h3F, 7'h3F, 7'h3F}) begin
            errors++;
            $display("FAIL rmid_disp: got a=%h b=%h expected a=%h b=%h", ca, cb, {7'h00, 7'h00, 7'h3F}, {7'h3F, 7'h3F, 7'h3F});
        end
    endtask

    task automatic test_values();
        int vals[8] = '{0, 9, 10, 99, 100, 128, 36, 247};
        int low;
        logic [20:0] ca, cb, ea, eb;
        foreach (vals[i]) begin
            do_convert(BW'(vals[i]), low);
            checks++;
            if (low !== 9) begin
                errors++;
                $display("FAIL val_ready_low v=%0d: got %0d expected 9", vals[i], low);
            end
            capture(ca, cb);
            for (int d = 0; d < NC; d++) begin
                ea[d*7 +: 7] = pat(vals[i], d, 1'b1);
                eb[d*7 +: 7] = pat(vals[i], d, 1'b0);
            end
            checks++;
            if (ca !== ea || cb !== eb) begin
                errors++;
                $display("FAIL val_segs v=%0d: got a=%h b=%h expected a=%h b=%h", vals[i], ca, cb, ea, eb);
            end
        end
    endtask

    task automatic test_random();
        int base;
        base = hs_n;
        repeat (300) begin
            @(negedge clk);
            bin_valid = 1'($urandom_range(0, 1));
            bin_in    = BW'($urandom);
        end
        @(negedge clk);
        bin_valid = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (hs_n - base < 10) begin
            errors++;
            $display("FAIL rand_handshakes: got %0d expected at least 10", hs_n - base);
        end
    endtask

    initial begin
        test_reset();
        test_convert_255();
        test_blanking();
        test_back_to_back();
        test_reset_mid();
        test_values();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
